// File: rtl/l2_input_buffer_pkg.sv
// Shared L2 inbound types: address widths, payload structs and FIFO occupancy helpers
// used by the input buffer and the decoder behind it.
package l2_input_buffer_pkg;

  localparam int ADDR_W      = 32;
  localparam int LINE_OFF_W  = 4;
  localparam int LINE_ADDR_W = ADDR_W - LINE_OFF_W;

  localparam int RSP_PAY_W_DEF = 64;
  localparam int FWD_PAY_W_DEF = 32;
  localparam int REQ_PAY_W_DEF = 32;

  typedef logic [ADDR_W-1:0]      addr_t;
  typedef logic [LINE_ADDR_W-1:0] line_addr_t;

  typedef struct packed {
    line_addr_t               addr;
    logic [RSP_PAY_W_DEF-1:0] pay;
  } l2_rsp_in_t;

  typedef struct packed {
    line_addr_t               addr;
    logic [FWD_PAY_W_DEF-1:0] pay;
  } l2_fwd_in_t;

  typedef struct packed {
    addr_t                    addr;
    logic [REQ_PAY_W_DEF-1:0] pay;
  } l2_cpu_req_t;

  // Two-entry channel FIFO occupancy
  typedef logic [1:0] fifo_cnt_t;
  localparam fifo_cnt_t FIFO_EMPTY = 2'd0;
  localparam fifo_cnt_t FIFO_FULL  = 2'd2;

  function automatic fifo_cnt_t cnt_next(fifo_cnt_t cnt, logic push, logic pop);
    fifo_cnt_t res;
    res = cnt;
    case ({push, pop})
      2'b10:   res = cnt + 2'd1;
      2'b01:   res = cnt - 2'd1;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/l2_input_buffer_if.sv
// One valid/ready channel carrying a line/byte address plus an opaque payload.
// master drives valid/addr/pay, slave returns ready.
interface l2_input_buffer_if #(
  parameter int AW = l2_input_buffer_pkg::LINE_ADDR_W,
  parameter int PW = l2_input_buffer_pkg::RSP_PAY_W_DEF
) ();

  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [PW-1:0] pay;

  modport master (output valid, output addr, output pay, input  ready);
  modport slave  (input  valid, input  addr, input  pay, output ready);

endinterface

// File: rtl/l2_input_buffer_chan_fifo2.sv
// Two-entry FIFO with a registered in_ready and zero-bubble head presentation.
// Storage is never reset; only occupancy, pointers and flags are.
module l2_chan_fifo2
  import l2_input_buffer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         empty_o
);

  fifo_cnt_t    count_q, count_d;
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic         in_ready_q, in_ready_d;
  logic         empty_q, empty_d;
  logic [W-1:0] mem_q [2];

  logic push, pop;

  assign push        = in_valid_i & in_ready_q;
  assign out_valid_o = (count_q != FIFO_EMPTY);
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    count_d    = cnt_next(count_q, push, pop);
    wptr_d     = push ? ~wptr_q : wptr_q;
    rptr_d     = pop  ? ~rptr_q : rptr_q;
    // ready looks at next occupancy so the sender sees it right after the edge
    in_ready_d = (count_d != FIFO_FULL);
    empty_d    = (count_d == FIFO_EMPTY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= FIFO_EMPTY;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      in_ready_q <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      in_ready_q <= in_ready_d;
      empty_q    <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_data_i;
    end
  end

  // Head is masked while empty so stale storage never shows after reset
  assign out_data_o = out_valid_o ? mem_q[rptr_q] : '0;
  assign in_ready_o = in_ready_q;
  assign empty_o    = empty_q;

  count_in_range: assert property (@(posedge clk) disable iff (!rst)
    count_q <= FIFO_FULL);

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    push |-> (count_q != FIFO_FULL));

endmodule

// File: rtl/l2_input_buffer.sv
// Staging buffer for the three L2 inbound channels ahead of l2_input_decoder.
// Each channel sits in its own 2-entry FIFO; external ready comes straight off a flop.
module l2_input_buffer
  import l2_input_buffer_pkg::*;
#(
  parameter int RSP_PAY_W = RSP_PAY_W_DEF,
  parameter int FWD_PAY_W = FWD_PAY_W_DEF,
  parameter int REQ_PAY_W = REQ_PAY_W_DEF,
  parameter int DEPTH     = 2
) (
  input  logic               clk,
  input  logic               rst,
  l2_input_buffer_if.slave   l2_rsp_in,
  l2_input_buffer_if.master  l2_rsp_in_int,
  l2_input_buffer_if.slave   l2_fwd_in,
  l2_input_buffer_if.master  l2_fwd_in_int,
  l2_input_buffer_if.slave   l2_cpu_req,
  l2_input_buffer_if.master  l2_cpu_req_int,
  output logic               inbuf_empty
);

  localparam int RSP_W = LINE_ADDR_W + RSP_PAY_W;
  localparam int FWD_W = LINE_ADDR_W + FWD_PAY_W;
  localparam int REQ_W = ADDR_W + REQ_PAY_W;

  if (DEPTH != 2) begin : g_depth_chk
    $error("l2_input_buffer supports DEPTH == 2 only");
  end

  logic [RSP_W-1:0] rsp_dout;
  logic [FWD_W-1:0] fwd_dout;
  logic [REQ_W-1:0] req_dout;
  logic             rsp_empty, fwd_empty, req_empty;

  l2_chan_fifo2 #(.W(RSP_W)) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (l2_rsp_in.valid),
    .in_ready_o  (l2_rsp_in.ready),
    .in_data_i   ({l2_rsp_in.addr, l2_rsp_in.pay}),
    .out_valid_o (l2_rsp_in_int.valid),
    .out_ready_i (l2_rsp_in_int.ready),
    .out_data_o  (rsp_dout),
    .empty_o     (rsp_empty)
  );

  l2_chan_fifo2 #(.W(FWD_W)) u_fwd_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (l2_fwd_in.valid),
    .in_ready_o  (l2_fwd_in.ready),
    .in_data_i   ({l2_fwd_in.addr, l2_fwd_in.pay}),
    .out_valid_o (l2_fwd_in_int.valid),
    .out_ready_i (l2_fwd_in_int.ready),
    .out_data_o  (fwd_dout),
    .empty_o     (fwd_empty)
  );

  l2_chan_fifo2 #(.W(REQ_W)) u_req_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (l2_cpu_req.valid),
    .in_ready_o  (l2_cpu_req.ready),
    .in_data_i   ({l2_cpu_req.addr, l2_cpu_req.pay}),
    .out_valid_o (l2_cpu_req_int.valid),
    .out_ready_i (l2_cpu_req_int.ready),
    .out_data_o  (req_dout),
    .empty_o     (req_empty)
  );

  // Address sits in the upper bits of each packed entry
  assign l2_rsp_in_int.addr  = rsp_dout[RSP_W-1 -: LINE_ADDR_W];
  assign l2_rsp_in_int.pay   = rsp_dout[RSP_PAY_W-1:0];
  assign l2_fwd_in_int.addr  = fwd_dout[FWD_W-1 -: LINE_ADDR_W];
  assign l2_fwd_in_int.pay   = fwd_dout[FWD_PAY_W-1:0];
  assign l2_cpu_req_int.addr = req_dout[REQ_W-1 -: ADDR_W];
  assign l2_cpu_req_int.pay  = req_dout[REQ_PAY_W-1:0];

  assign inbuf_empty = rsp_empty & fwd_empty & req_empty;

endmodule

// File: tb/tb_l2_input_buffer.sv
// Bench for l2_input_buffer: reset, directed table, corner sequences and a random run
// checked against per-channel queue models.
module tb_l2_input_buffer;
  import l2_input_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inbuf_empty;

  always #5 clk = ~clk;

  l2_input_buffer_if #(.AW(LINE_ADDR_W), .PW(64)) rsp_ext ();
  l2_input_buffer_if #(.AW(LINE_ADDR_W), .PW(64)) rsp_dec ();
  l2_input_buffer_if #(.AW(LINE_ADDR_W), .PW(32)) fwd_ext ();
  l2_input_buffer_if #(.AW(LINE_ADDR_W), .PW(32)) fwd_dec ();
  l2_input_buffer_if #(.AW(ADDR_W),      .PW(32)) cpu_ext ();
  l2_input_buffer_if #(.AW(ADDR_W),      .PW(32)) cpu_dec ();

  l2_input_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .l2_rsp_in      (rsp_ext),
    .l2_rsp_in_int  (rsp_dec),
    .l2_fwd_in      (fwd_ext),
    .l2_fwd_in_int  (fwd_dec),
    .l2_cpu_req     (cpu_ext),
    .l2_cpu_req_int (cpu_dec),
    .inbuf_empty    (inbuf_empty)
  );

  typedef struct {
    logic [31:0] a;
    logic [63:0] p;
  } ent_t;

  ent_t  mq [3][$];
  string cn [3] = '{"rsp", "fwd", "cpu"};
  bit    last_push [3];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  function automatic logic [63:0] pay_of(logic [31:0] a);
    return {a, a ^ 32'h5A5A_5A5A};
  endfunction

  task automatic set_in(int c, logic v, logic [31:0] a);
    logic [63:0] p;
    p = pay_of(a);
    case (c)
      0: begin rsp_ext.valid = v; rsp_ext.addr = a[LINE_ADDR_W-1:0]; rsp_ext.pay = p; end
      1: begin fwd_ext.valid = v; fwd_ext.addr = a[LINE_ADDR_W-1:0]; fwd_ext.pay = p[31:0]; end
      default: begin cpu_ext.valid = v; cpu_ext.addr = a; cpu_ext.pay = p[31:0]; end
    endcase
  endtask

  task automatic set_rdy(int c, logic r);
    case (c)
      0: rsp_dec.ready = r;
      1: fwd_dec.ready = r;
      default: cpu_dec.ready = r;
    endcase
  endtask

  task automatic get_in(int c, output logic v, output logic [31:0] a,
                        output logic [63:0] p, output logic r);
    case (c)
      0: begin v = rsp_ext.valid; a = 32'(rsp_ext.addr); p = rsp_ext.pay; r = rsp_dec.ready; end
      1: begin v = fwd_ext.valid; a = 32'(fwd_ext.addr); p = 64'(fwd_ext.pay); r = fwd_dec.ready; end
      default: begin v = cpu_ext.valid; a = cpu_ext.addr; p = 64'(cpu_ext.pay); r = cpu_dec.ready; end
    endcase
  endtask

  task automatic get_out(int c, output logic v, output logic r,
                         output logic [31:0] a, output logic [63:0] p);
    case (c)
      0: begin v = rsp_dec.valid; r = rsp_ext.ready; a = 32'(rsp_dec.addr); p = rsp_dec.pay; end
      1: begin v = fwd_dec.valid; r = fwd_ext.ready; a = 32'(fwd_dec.addr); p = 64'(fwd_dec.pay); end
      default: begin v = cpu_dec.valid; r = cpu_ext.ready; a = cpu_dec.addr; p = 64'(cpu_dec.pay); end
    endcase
  endtask

  // Compare every output with what the queue models imply
  task automatic check_all(string tag);
    logic v, r;
    logic [31:0] a;
    logic [63:0] p;
    bit all_empty;
    all_empty = 1'b1;
    for (int c = 0; c < 3; c++) begin
      get_out(c, v, r, a, p);
      chk($sformatf("%s_%s_valid_int", tag, cn[c]), 64'(v), 64'(mq[c].size() != 0));
      chk($sformatf("%s_%s_ready", tag, cn[c]), 64'(r), 64'(mq[c].size() < 2));
      chk($sformatf("%s_%s_head_addr", tag, cn[c]), 64'(a),
          (mq[c].size() != 0) ? 64'(mq[c][0].a) : 64'd0);
      chk($sformatf("%s_%s_head_pay", tag, cn[c]), p,
          (mq[c].size() != 0) ? mq[c][0].p : 64'd0);
      if (mq[c].size() != 0) all_empty = 1'b0;
    end
    chk($sformatf("%s_inbuf_empty", tag), 64'(inbuf_empty), 64'(all_empty));
  endtask

  // One clock: model the edge from the inputs currently applied, then check
  task automatic cycle(string tag);
    logic v [3];
    logic r [3];
    logic [31:0] a [3];
    logic [63:0] p [3];
    bit push [3];
    bit pop [3];
    ent_t e;
    for (int c = 0; c < 3; c++) begin
      get_in(c, v[c], a[c], p[c], r[c]);
      push[c] = (v[c] === 1'b1) && (mq[c].size() < 2);
      pop[c]  = (r[c] === 1'b1) && (mq[c].size() != 0);
    end
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (pop[c]) void'(mq[c].pop_front());
      if (push[c]) begin
        e.a = a[c];
        e.p = p[c];
        mq[c].push_back(e);
      end
      last_push[c] = push[c];
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle_all();
    for (int c = 0; c < 3; c++) begin
      set_in(c, 1'b0, 32'd0);
      set_rdy(c, 1'b0);
    end
  endtask

  typedef struct {
    logic        v;
    logic [27:0] a;
    logic        rdy;
    logic        ev;
    logic        erdy;
    logic [27:0] ea;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic v, r;
    logic [31:0] a;
    logic [63:0] p;

    idle_all();
    #1 rst = 1'b0;
    #2;
    check_all("reset");
    #9 rst = 1'b1;

    // rsp channel fill / stall / drain, expected values worked by hand
    tbl[0] = '{1'b1, 28'h1A2B, 1'b0, 1'b1, 1'b1, 28'h1A2B};
    tbl[1] = '{1'b1, 28'h1A2C, 1'b0, 1'b1, 1'b0, 28'h1A2B};
    tbl[2] = '{1'b1, 28'h1A2D, 1'b0, 1'b1, 1'b0, 28'h1A2B};
    tbl[3] = '{1'b1, 28'h1A2D, 1'b1, 1'b1, 1'b1, 28'h1A2C};
    tbl[4] = '{1'b1, 28'h1A2D, 1'b0, 1'b1, 1'b0, 28'h1A2C};
    tbl[5] = '{1'b0, 28'h0000, 1'b1, 1'b1, 1'b1, 28'h1A2D};
    tbl[6] = '{1'b0, 28'h0000, 1'b1, 1'b0, 1'b1, 28'h0000};
    tbl[7] = '{1'b0, 28'h0000, 1'b1, 1'b0, 1'b1, 28'h0000};
    for (int i = 0; i < 8; i++) begin
      set_in(0, tbl[i].v, 32'(tbl[i].a));
      set_rdy(0, tbl[i].rdy);
      cycle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_valid_int", i), 64'(rsp_dec.valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 64'(rsp_ext.ready), 64'(tbl[i].erdy));
      chk($sformatf("tbl%0d_head", i), 64'(rsp_dec.addr), 64'(tbl[i].ea));
    end
    idle_all();

    // cpu_req streaming at one per cycle
    set_rdy(2, 1'b1);
    for (int k = 0; k < 10; k++) begin
      set_in(2, 1'b1, 32'h100 + 32'(4 * k));
      cycle("stream");
      chk("stream_head", 64'(cpu_dec.addr), 64'h100 + 64'(4 * k));
      chk("stream_ready", 64'(cpu_ext.ready), 64'd1);
    end
    set_in(2, 1'b0, 32'd0);
    cycle("stream_end");
    idle_all();

    // fwd push and pop in the same cycle at count 1
    set_in(1, 1'b1, 32'h33);
    cycle("fwd_a");
    set_in(1, 1'b1, 32'h55);
    set_rdy(1, 1'b1);
    cycle("fwd_b");
    chk("fwd_pp_head", 64'(fwd_dec.addr), 64'h55);
    chk("fwd_pp_ready", 64'(fwd_ext.ready), 64'd1);
    set_in(1, 1'b0, 32'd0);
    cycle("fwd_c");
    chk("fwd_pp_drained", 64'(fwd_dec.valid), 64'd0);
    idle_all();

    // one entry per channel, decoder pops rsp only, then the rest
    set_in(0, 1'b1, 32'hAA);
    set_in(1, 1'b1, 32'hBB);
    set_in(2, 1'b1, 32'hCC);
    cycle("x_fill");
    idle_all();
    set_rdy(0, 1'b1);
    cycle("x_pop_rsp");
    chk("x_fwd_head", 64'(fwd_dec.addr), 64'hBB);
    chk("x_cpu_head", 64'(cpu_dec.addr), 64'hCC);
    chk("x_not_empty", 64'(inbuf_empty), 64'd0);
    set_rdy(1, 1'b1);
    set_rdy(2, 1'b1);
    cycle("x_drain");
    chk("x_empty", 64'(inbuf_empty), 64'd1);
    idle_all();

    // reset with every channel full
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) set_in(c, 1'b1, 32'h700 + 32'(16 * c + k));
      cycle("rst_fill");
    end
    idle_all();
    @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) mq[c].delete();
    #1;
    check_all("rst_mid");
    #3 rst = 1'b1;
    for (int c = 0; c < 3; c++) set_rdy(c, 1'b1);
    for (int k = 0; k < 3; k++) cycle("rst_after");
    idle_all();

    // random traffic against the queue models; senders hold until accepted
    for (int c = 0; c < 3; c++) last_push[c] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 3; c++) begin
        get_in(c, v, a, p, r);
        if (v !== 1'b1 || last_push[c])
          set_in(c, 1'($urandom_range(0, 2) != 0), $urandom);
        set_rdy(c, 1'($urandom_range(0, 1)));
      end
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
